// File: rtl/axi4_ram_arbiter.sv
// axi4_ram_arbiter
// Arbitrates between an instruction-fetch read port (if_*) and a load/store
// port (ls_*) in front of a single AXI4-lite-style RAM port (ram_*). Only one
// transaction is outstanding at a time.
//
// Ports:
//   clock, reset        - single rising-edge clock, synchronous active-low reset
//   if_ar*/if_r*        - fetch read request and response
//   ls_ar*/ls_r*        - load/store read request and response
//   ls_aw*/ls_w*/ls_b*  - load/store write address, data and completion pulse
//   ram_ar*/ram_rdata   - RAM read address channel and read data
//   ram_aw*/ram_w*/ram_bvalid - RAM write address, write data and response
module axi4_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_arvalid,
  input  logic [ADDR_W-1:0]   if_araddr,
  output logic                if_arready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_arvalid,
  input  logic [ADDR_W-1:0]   ls_araddr,
  output logic                ls_arready,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  input  logic                ls_awvalid,
  input  logic [ADDR_W-1:0]   ls_awaddr,
  output logic                ls_awready,
  input  logic                ls_wvalid,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_wready,
  output logic                ls_bvalid,
  output logic                ram_arvalid,
  output logic [ADDR_W-1:0]   ram_araddr,
  input  logic                ram_arready,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                ram_awvalid,
  output logic [ADDR_W-1:0]   ram_awaddr,
  input  logic                ram_awready,
  output logic                ram_wvalid,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  input  logic                ram_wready,
  input  logic                ram_bvalid
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDATA,
    WR,
    WRESP
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  state_t              state_q, state_d;
  logic                prio_ls_q, prio_ls_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic                ls_bvalid_q, ls_bvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

  logic ls_wr_req;
  logic ls_req;
  logic grant_if;
  logic grant_ls_wr;
  logic grant_ls_rd;

  // Grant decision in IDLE. A write needs both address and data valid. The
  // readies are gated by reset so nothing looks accepted on a reset edge.
  // prio_ls_q set means LS was not granted last and now wins a tie with IF.
  always_comb begin
    ls_wr_req   = ls_awvalid && ls_wvalid;
    ls_req      = ls_wr_req || ls_arvalid;
    grant_if    = 1'b0;
    grant_ls_wr = 1'b0;
    grant_ls_rd = 1'b0;
    if (reset && (state_q == IDLE)) begin
      if (if_arvalid && (!ls_req || !prio_ls_q)) begin
        grant_if = 1'b1;
      end else if (ls_wr_req) begin
        grant_ls_wr = 1'b1;
      end else if (ls_arvalid) begin
        grant_ls_rd = 1'b1;
      end
    end
  end

  // Next-state and datapath update for the single outstanding transaction.
  always_comb begin
    state_d     = state_q;
    prio_ls_d   = prio_ls_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    ls_bvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d   = RD;
          owner_d   = OWNER_IF;
          addr_d    = if_araddr;
          prio_ls_d = 1'b1;
        end else if (grant_ls_wr) begin
          state_d   = WR;
          owner_d   = OWNER_LS;
          addr_d    = ls_awaddr;
          wdata_d   = ls_wdata;
          wstrb_d   = ls_wstrb;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          prio_ls_d = 1'b0;
        end else if (grant_ls_rd) begin
          state_d   = RD;
          owner_d   = OWNER_LS;
          addr_d    = ls_araddr;
          prio_ls_d = 1'b0;
        end
      end
      RD: begin
        if (ram_arready) begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (owner_q == OWNER_LS) begin
          ls_rdata_d  = ram_rdata;
          ls_rvalid_d = 1'b1;
        end else begin
          if_rdata_d  = ram_rdata;
          if_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      WR: begin
        // Address and data channels complete independently.
        aw_pend_d = aw_pend_q && !ram_awready;
        w_pend_d  = w_pend_q && !ram_wready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (ram_bvalid) begin
          ls_bvalid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; a reset drops any transaction in flight without a response.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      prio_ls_q   <= 1'b0;
      owner_q     <= OWNER_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_bvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_ls_q   <= prio_ls_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_bvalid_q <= ls_bvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_arready  = grant_if;
  assign ls_arready  = grant_ls_rd;
  assign ls_awready  = grant_ls_wr;
  assign ls_wready   = grant_ls_wr;
  assign if_rvalid   = if_rvalid_q;
  assign ls_rvalid   = ls_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign ls_bvalid   = ls_bvalid_q;

  assign ram_arvalid = (state_q == RD);
  assign ram_araddr  = addr_q;
  assign ram_awvalid = (state_q == WR) && aw_pend_q;
  assign ram_awaddr  = addr_q;
  assign ram_wvalid  = (state_q == WR) && w_pend_q;
  assign ram_wdata   = wdata_q;
  assign ram_wstrb   = wstrb_q;

endmodule

// File: tb/tb_axi4_ram_arbiter.sv
// tb_axi4_ram_arbiter
// Directed-vector testbench for axi4_ram_arbiter. Inputs are driven on the
// falling edge and outputs sampled 1 ns later, away from the rising edge.
module tb_axi4_ram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic                clock;
  logic                reset;
  logic                if_arvalid;
  logic [ADDR_W-1:0]   if_araddr;
  logic                if_arready;
  logic                if_rvalid;
  logic [DATA_W-1:0]   if_rdata;
  logic                ls_arvalid;
  logic [ADDR_W-1:0]   ls_araddr;
  logic                ls_arready;
  logic                ls_rvalid;
  logic [DATA_W-1:0]   ls_rdata;
  logic                ls_awvalid;
  logic [ADDR_W-1:0]   ls_awaddr;
  logic                ls_awready;
  logic                ls_wvalid;
  logic [DATA_W-1:0]   ls_wdata;
  logic [DATA_W/8-1:0] ls_wstrb;
  logic                ls_wready;
  logic                ls_bvalid;
  logic                ram_arvalid;
  logic [ADDR_W-1:0]   ram_araddr;
  logic                ram_arready;
  logic [DATA_W-1:0]   ram_rdata;
  logic                ram_awvalid;
  logic [ADDR_W-1:0]   ram_awaddr;
  logic                ram_awready;
  logic                ram_wvalid;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W/8-1:0] ram_wstrb;
  logic                ram_wready;
  logic                ram_bvalid;

  int checkCount = 0;
  int passCount  = 0;

  logic [DATA_W-1:0] tieData [4];
  logic              expIf;

  axi4_ram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .if_arvalid (if_arvalid),
    .if_araddr  (if_araddr),
    .if_arready (if_arready),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_arvalid (ls_arvalid),
    .ls_araddr  (ls_araddr),
    .ls_arready (ls_arready),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .ls_awvalid (ls_awvalid),
    .ls_awaddr  (ls_awaddr),
    .ls_awready (ls_awready),
    .ls_wvalid  (ls_wvalid),
    .ls_wdata   (ls_wdata),
    .ls_wstrb   (ls_wstrb),
    .ls_wready  (ls_wready),
    .ls_bvalid  (ls_bvalid),
    .ram_arvalid(ram_arvalid),
    .ram_araddr (ram_araddr),
    .ram_arready(ram_arready),
    .ram_rdata  (ram_rdata),
    .ram_awvalid(ram_awvalid),
    .ram_awaddr (ram_awaddr),
    .ram_awready(ram_awready),
    .ram_wvalid (ram_wvalid),
    .ram_wdata  (ram_wdata),
    .ram_wstrb  (ram_wstrb),
    .ram_wready (ram_wready),
    .ram_bvalid (ram_bvalid)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the four requester valids at once.
  task automatic applyStimulus(input logic ifAr, input logic lsAr,
                               input logic lsAw, input logic lsW);
    if_arvalid = ifAr;
    ls_arvalid = lsAr;
    ls_awvalid = lsAw;
    ls_wvalid  = lsW;
  endtask

  // Advance one full cycle, landing on the next falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    tieData[0] = 64'hA0A0_0000_0000_0001;
    tieData[1] = 64'hB1B1_0000_0000_0002;
    tieData[2] = 64'hC2C2_0000_0000_0003;
    tieData[3] = 64'hD3D3_0000_0000_0004;
    expIf = 1'b0;

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    if_araddr = '0; ls_araddr = '0; ls_awaddr = '0;
    ls_wdata = '0; ls_wstrb = '0;
    ram_arready = 1'b0; ram_rdata = '0; ram_awready = 1'b0;
    ram_wready = 1'b0; ram_bvalid = 1'b0;

    // Reset state, with requests pending so readies must still stay low.
    @(negedge clock);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    #1;
    checkOutput("rst if_arready", if_arready, 1'b0);
    checkOutput("rst ls readies", {ls_arready, ls_awready, ls_wready}, 3'b000);
    checkOutput("rst ram valids", {ram_arvalid, ram_awvalid, ram_wvalid}, 3'b000);
    checkOutput("rst rsp valids", {if_rvalid, ls_rvalid, ls_bvalid}, 3'b000);
    checkOutput("rst if_rdata", if_rdata, 64'h0);
    checkOutput("rst ls_rdata", ls_rdata, 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();

    // Single fetch read, immediate ram_arready.
    ram_arready = 1'b1;
    if_araddr = 32'h8000_0000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("rd1 if_arready", if_arready, 1'b1);
    checkOutput("rd1 ls readies", {ls_arready, ls_awready, ls_wready}, 3'b000);
    checkOutput("rd1 idle ram_arvalid", ram_arvalid, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("rd1 ram_arvalid", ram_arvalid, 1'b1);
    checkOutput("rd1 ram_araddr", ram_araddr, 64'h8000_0000);
    checkOutput("rd1 if_arready low", if_arready, 1'b0);
    tick();
    ram_rdata = 64'h1122_3344_5566_7788;
    #1;
    checkOutput("rd1 rdata ram_arvalid", ram_arvalid, 1'b0);
    checkOutput("rd1 early if_rvalid", if_rvalid, 1'b0);
    tick();
    ram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checkOutput("rd1 if_rvalid", if_rvalid, 1'b1);
    checkOutput("rd1 if_rdata", if_rdata, 64'h1122_3344_5566_7788);
    checkOutput("rd1 ls_rvalid", ls_rvalid, 1'b0);
    tick();
    #1;
    checkOutput("rd1 if_rvalid pulse", if_rvalid, 1'b0);
    checkOutput("rd1 if_rdata hold", if_rdata, 64'h1122_3344_5566_7788);

    // Round-robin ties from reset: IF, LS, IF, LS.
    doReset();
    ram_arready = 1'b1;
    if_araddr = 32'h0000_1000;
    ls_araddr = 32'h0000_2000;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      expIf = (t % 2 == 0);
      #1;
      checkOutput("tie if_arready", if_arready, expIf);
      checkOutput("tie ls_arready", ls_arready, !expIf);
      if (t > 0) begin
        if (expIf) begin
          checkOutput("tie ls_rvalid", ls_rvalid, 1'b1);
          checkOutput("tie ls_rdata", ls_rdata, tieData[t-1]);
          checkOutput("tie if_rvalid idle", if_rvalid, 1'b0);
        end else begin
          checkOutput("tie if_rvalid", if_rvalid, 1'b1);
          checkOutput("tie if_rdata", if_rdata, tieData[t-1]);
          checkOutput("tie ls_rvalid idle", ls_rvalid, 1'b0);
        end
      end
      tick();
      #1;
      checkOutput("tie ram_arvalid", ram_arvalid, 1'b1);
      checkOutput("tie ram_araddr", ram_araddr, expIf ? 64'h1000 : 64'h2000);
      checkOutput("tie busy readies", {if_arready, ls_arready}, 2'b00);
      tick();
      ram_rdata = tieData[t];
      #1;
      checkOutput("tie rdata ram_arvalid", ram_arvalid, 1'b0);
      tick();
    end
    #1;
    checkOutput("tie last ls_rvalid", ls_rvalid, 1'b1);
    checkOutput("tie last ls_rdata", ls_rdata, tieData[3]);
    checkOutput("tie if_rdata hold", if_rdata, tieData[2]);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // LS write with late ram_wready and delayed ram_bvalid; write beats LS read.
    doReset();
    ram_awready = 1'b1;
    ram_wready = 1'b0;
    ls_awaddr = 32'h8000_0010;
    ls_wdata = 64'h0000_0000_DEAD_BEEF;
    ls_wstrb = 8'h0F;
    ls_araddr = 32'h0000_3000;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("wr ls_awready", ls_awready, 1'b1);
    checkOutput("wr ls_wready", ls_wready, 1'b1);
    checkOutput("wr ls_arready", ls_arready, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    ls_awaddr = '0; ls_wdata = '0; ls_wstrb = '0;
    #1;
    checkOutput("wr ram_awvalid", ram_awvalid, 1'b1);
    checkOutput("wr ram_wvalid", ram_wvalid, 1'b1);
    checkOutput("wr ram_awaddr", ram_awaddr, 64'h8000_0010);
    checkOutput("wr ram_wdata", ram_wdata, 64'hDEAD_BEEF);
    checkOutput("wr ram_wstrb", ram_wstrb, 8'h0F);
    tick();
    ram_bvalid = 1'b1;
    #1;
    checkOutput("wr aw done", ram_awvalid, 1'b0);
    checkOutput("wr w held", ram_wvalid, 1'b1);
    checkOutput("wr wdata held", ram_wdata, 64'hDEAD_BEEF);
    tick();
    ram_bvalid = 1'b0;
    ram_wready = 1'b1;
    #1;
    checkOutput("wr w still held", ram_wvalid, 1'b1);
    checkOutput("wr stray bvalid", ls_bvalid, 1'b0);
    tick();
    ram_wready = 1'b0;
    #1;
    checkOutput("wr wresp valids", {ram_arvalid, ram_awvalid, ram_wvalid}, 3'b000);
    checkOutput("wr wresp bvalid0", ls_bvalid, 1'b0);
    tick();
    #1;
    checkOutput("wr wresp bvalid1", ls_bvalid, 1'b0);
    tick();
    ram_bvalid = 1'b1;
    #1;
    checkOutput("wr wresp bvalid2", ls_bvalid, 1'b0);
    tick();
    ram_bvalid = 1'b0;
    #1;
    checkOutput("wr ls_bvalid", ls_bvalid, 1'b1);
    tick();
    ram_bvalid = 1'b1;
    #1;
    checkOutput("wr ls_bvalid pulse", ls_bvalid, 1'b0);
    tick();
    ram_bvalid = 1'b0;
    #1;
    checkOutput("wr idle bvalid ignored", ls_bvalid, 1'b0);

    // Lone write address or lone write data is never accepted.
    ram_arready = 1'b1;
    ls_awaddr = 32'h8000_0020;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("lone aw readies", {ls_awready, ls_wready}, 2'b00);
    tick();
    #1;
    checkOutput("lone aw no write", ram_awvalid, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("lone w readies", {ls_awready, ls_wready}, 2'b00);
    tick();
    if_araddr = 32'h8000_0100;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("lone aw if_arready", if_arready, 1'b1);
    checkOutput("lone aw ls_awready", ls_awready, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("lone aw ram_arvalid", ram_arvalid, 1'b1);
    checkOutput("lone aw ram_awvalid", ram_awvalid, 1'b0);
    tick();
    ram_rdata = 64'hCAFE_F00D_0123_4567;
    tick();
    #1;
    checkOutput("lone aw if_rvalid", if_rvalid, 1'b1);
    checkOutput("lone aw if_rdata", if_rdata, 64'hCAFE_F00D_0123_4567);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset while a read is stalled in RD.
    ram_arready = 1'b0;
    if_araddr = 32'h8000_0200;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("abort if_arready", if_arready, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("abort ram_arvalid", ram_arvalid, 1'b1);
    tick();
    #1;
    checkOutput("abort stall ram_arvalid", ram_arvalid, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("abort ram_arvalid low", ram_arvalid, 1'b0);
    checkOutput("abort if_rvalid", if_rvalid, 1'b0);
    checkOutput("abort if_rdata cleared", if_rdata, 64'h0);
    ram_arready = 1'b1;
    tick();
    #1;
    checkOutput("abort no late rvalid", if_rvalid, 1'b0);
    checkOutput("abort still idle", ram_arvalid, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("abort ptr if_arready", if_arready, 1'b1);
    checkOutput("abort ptr ls_arready", ls_arready, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axi4_ram_arbiter.md
AXI4_RAM_ARBITER -- requirements
Module: axi4_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width on all ports.
REQ-002 SHALL have parameter DATA_W, default 64, data width; strobe width DATA_W/8.
REQ-003 SHALL have port clock, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous active-low reset.
REQ-005 SHALL have ports if_arvalid, input, 1, and if_araddr, input, ADDR_W: fetch read request.
REQ-006 SHALL have ports if_arready, output, 1; if_rvalid, output, 1; if_rdata, output, DATA_W: fetch accept and response.
REQ-007 SHALL have ports ls_arvalid, input, 1; ls_araddr, input, ADDR_W; ls_arready, output, 1: load/store read request.
REQ-008 SHALL have ports ls_rvalid, output, 1, and ls_rdata, output, DATA_W: load/store read response.
REQ-009 SHALL have ports ls_awvalid, input, 1; ls_awaddr, input, ADDR_W; ls_awready, output, 1: write address.
REQ-010 SHALL have ports ls_wvalid, input, 1; ls_wdata, input, DATA_W; ls_wstrb, input, DATA_W/8; ls_wready, output, 1: write data.
REQ-011 SHALL have port ls_bvalid, output, 1: write-complete pulse.
REQ-012 SHALL have ports ram_arvalid, output, 1; ram_araddr, output, ADDR_W; ram_arready, input, 1; ram_rdata, input, DATA_W: RAM read side.
REQ-013 SHALL have ports ram_awvalid, output, 1; ram_awaddr, output, ADDR_W; ram_awready, input, 1: RAM write address.
REQ-014 SHALL have ports ram_wvalid, output, 1; ram_wdata, output, DATA_W; ram_wstrb, output, DATA_W/8; ram_wready, input, 1; ram_bvalid, input, 1: RAM write data and response.

Function
REQ-015 SHALL implement FSM states IDLE, RD, RDATA, WR, WRESP; one transaction outstanding at a time.
REQ-016 IDLE candidates SHALL be: IF read (if_arvalid); LS write (ls_awvalid AND ls_wvalid); LS read (ls_arvalid); a lone ls_awvalid or ls_wvalid SHALL NOT be accepted.
REQ-017 LS write SHALL beat LS read; between IF and LS a 1-bit round-robin pointer SHALL give priority to the requester not granted last; pointer resets to favour IF.
REQ-018 On grant (IDLE, registered at clock edge) the winner's ready(s) SHALL pulse high for exactly that cycle; addr, wdata, wstrb, owner latched; all requester readies low in every other cycle.
REQ-019 Read: IDLE->RD; RD holds ram_arvalid with latched address until ram_arready; handshake cycle ->RDATA.
REQ-020 RDATA: ram_rdata (valid the cycle after ram handshake) SHALL be registered; next cycle owner rvalid pulses one cycle with that data; FSM ->IDLE same edge.
REQ-021 if_rdata/ls_rdata SHALL hold last returned value until the next read to that requester completes.
REQ-022 Read latency: accept cycle N, ram_arready in N+1 -> owner rvalid in N+3; each ram_arready stall cycle adds one.
REQ-023 Write: IDLE->WR; ram_awvalid and ram_wvalid asserted together, each deasserted independently after its own handshake; both done ->WRESP.
REQ-024 WRESP waits for ram_bvalid; ls_bvalid SHALL pulse one cycle the cycle after ram_bvalid; FSM ->IDLE; ram_bvalid outside WRESP ignored.
REQ-025 Simultaneous requests SHALL never cause both requesters' readies high in one cycle.
REQ-026 RAM-side valids SHALL be low in IDLE, RDATA, WRESP.

Reset
REQ-027 reset low at a clock edge SHALL force IDLE, pointer to IF-favoured, all valids/readies/rvalid/bvalid 0, rdata registers 0.
REQ-028 Reset mid-transaction SHALL abort without emitting rvalid/bvalid; RAM valids drop at that edge.

Verification
REQ-029 IF read 0x80000000, ram_arready immediate, ram_rdata 0x1122334455667788 -> if_rvalid one cycle 3 cycles after accept, data matches.
REQ-030 IF and LS read both valid from reset -> IF granted first, LS next; repeated ties alternate.
REQ-031 LS write 0x80000010, wdata 0xDEADBEEF, wstrb 0x0F, ram_wready 2 cycles late, ram_bvalid 3 cycles later -> ram signals held correctly, single ls_bvalid pulse.
REQ-032 ls_awvalid without ls_wvalid -> no grant; IF read proceeds.
REQ-033 reset low while in RD with ram_arready held 0 -> IDLE next cycle, no rvalid, ram_arvalid 0.
